// File: rtl/cv32e40p_fpu_wb_scheduler.sv
// FPU issue/writeback scheduler: latency-indexed reservation table
// plus iterative DIV/SQRT tracking for the shared regfile write port.
module cv32e40p_fpu_wb_scheduler #(
  parameter int FPU_ADDMUL_LAT = 2,
  parameter int FPU_OTHERS_LAT = 2,
  parameter bit ZFINX          = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic [1:0] op_class_i,
  input  logic [5:0] rd_i,
  input  logic       rd_we_i,
  input  logic [5:0] rs1_i,
  input  logic [5:0] rs2_i,
  input  logic [5:0] rs3_i,
  input  logic [2:0] rs_used_i,
  output logic       gnt_o,
  output logic       stall_raw_o,
  output logic       stall_port_o,
  input  logic       fpu_rvalid_i,
  output logic       wb_valid_o,
  output logic       wb_we_o,
  output logic [5:0] wb_addr_o,
  input  logic       flush_i,
  output logic       busy_o,
  output logic       err_o
);
  localparam int MAX_LAT = (FPU_ADDMUL_LAT > FPU_OTHERS_LAT) ?
                           FPU_ADDMUL_LAT : FPU_OTHERS_LAT;

  logic [MAX_LAT-1:0] vld_q, vld_d;
  logic [MAX_LAT-1:0] we_q, we_d;
  logic [MAX_LAT-1:0] kill_q, kill_d;
  logic [5:0]         addr_q [MAX_LAT];
  logic [5:0]         addr_d [MAX_LAT];
  logic               iter_q, iter_d;
  logic               it_we_q, it_we_d;
  logic               it_kill_q, it_kill_d;
  logic [5:0]         it_addr_q, it_addr_d;

  logic cls_am, cls_ot, cls_ds, cls_rsv;
  logic raw, port_blk, iter_ret, trk_we, issue;
  logic [MAX_LAT:0] vld_ext;
  logic [5:0]       chk_a [4];
  logic [3:0]       chk_en;

  assign cls_am  = op_class_i == 2'd0;
  assign cls_ot  = op_class_i == 2'd1;
  assign cls_ds  = op_class_i == 2'd2;
  assign cls_rsv = op_class_i == 2'd3;

  assign chk_a[0] = rs1_i;
  assign chk_a[1] = rs2_i;
  assign chk_a[2] = rs3_i;
  assign chk_a[3] = rd_i;
  assign chk_en   = {rd_we_i, rs_used_i};

  // killed entries still hold their register until they drain
  always_comb begin
    raw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (chk_en[c] && !(ZFINX && chk_a[c] == 6'd0)) begin
        for (int k = 0; k < MAX_LAT; k++)
          if (vld_q[k] && we_q[k] && addr_q[k] == chk_a[c])
            raw = 1'b1;
        if (iter_q && it_we_q && it_addr_q == chk_a[c])
          raw = 1'b1;
      end
    end
  end

  // padded so slot[MAX_LAT] reads as empty
  assign vld_ext = {1'b0, vld_q};

  always_comb begin
    port_blk = iter_q;
    unique case (1'b1)
      cls_am:  port_blk = port_blk | vld_ext[FPU_ADDMUL_LAT];
      cls_ot:  port_blk = port_blk | vld_ext[FPU_OTHERS_LAT];
      cls_ds:  port_blk = port_blk | (|vld_q);
      default: port_blk = port_blk;
    endcase
  end

  assign issue        = req_i & ~cls_rsv;
  assign stall_raw_o  = issue & raw;
  assign stall_port_o = issue & port_blk;
  assign gnt_o        = rst_n & issue & ~raw & ~port_blk;

  assign iter_ret   = fpu_rvalid_i & ~vld_q[0] & iter_q;
  assign wb_valid_o = vld_q[0] | iter_ret;
  assign wb_addr_o  = vld_q[0] ? addr_q[0] :
                      (iter_ret ? it_addr_q : 6'd0);
  assign wb_we_o    = vld_q[0] ?
                      (fpu_rvalid_i & we_q[0] & ~kill_q[0]) :
                      (iter_ret & it_we_q & ~it_kill_q);
  assign err_o      = rst_n & ((req_i & cls_rsv) |
                      (vld_q[0] & ~fpu_rvalid_i) |
                      (fpu_rvalid_i & ~vld_q[0] & ~iter_q));
  assign busy_o     = (|vld_q) | iter_q;

  assign trk_we = rd_we_i & ~(ZFINX & (rd_i == 6'd0));

  always_comb begin
    for (int k = 0; k < MAX_LAT - 1; k++) begin
      vld_d[k]  = vld_q[k+1];
      we_d[k]   = we_q[k+1];
      kill_d[k] = kill_q[k+1] | (flush_i & vld_q[k+1]);
      addr_d[k] = addr_q[k+1];
    end
    vld_d[MAX_LAT-1]  = 1'b0;
    we_d[MAX_LAT-1]   = 1'b0;
    kill_d[MAX_LAT-1] = 1'b0;
    addr_d[MAX_LAT-1] = 6'd0;
    iter_d    = iter_q & ~iter_ret;
    it_we_d   = it_we_q;
    it_kill_d = it_kill_q | (flush_i & iter_q);
    it_addr_d = it_addr_q;
    if (gnt_o) begin
      unique case (1'b1)
        cls_am: begin
          vld_d[FPU_ADDMUL_LAT-1]  = 1'b1;
          we_d[FPU_ADDMUL_LAT-1]   = trk_we;
          kill_d[FPU_ADDMUL_LAT-1] = flush_i;
          addr_d[FPU_ADDMUL_LAT-1] = rd_i;
        end
        cls_ot: begin
          vld_d[FPU_OTHERS_LAT-1]  = 1'b1;
          we_d[FPU_OTHERS_LAT-1]   = trk_we;
          kill_d[FPU_OTHERS_LAT-1] = flush_i;
          addr_d[FPU_OTHERS_LAT-1] = rd_i;
        end
        cls_ds: begin
          iter_d    = 1'b1;
          it_we_d   = trk_we;
          it_kill_d = flush_i;
          it_addr_d = rd_i;
        end
        default: iter_d = iter_d;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      we_q      <= '0;
      kill_q    <= '0;
      for (int k = 0; k < MAX_LAT; k++)
        addr_q[k] <= 6'd0;
      iter_q    <= 1'b0;
      it_we_q   <= 1'b0;
      it_kill_q <= 1'b0;
      it_addr_q <= 6'd0;
    end else begin
      vld_q     <= vld_d;
      we_q      <= we_d;
      kill_q    <= kill_d;
      for (int k = 0; k < MAX_LAT; k++)
        addr_q[k] <= addr_d[k];
      iter_q    <= iter_d;
      it_we_q   <= it_we_d;
      it_kill_q <= it_kill_d;
      it_addr_q <= it_addr_d;
    end
  end

endmodule
